// File: rtl/bf_io_pkg.sv
// Shared types and bus address map for the bfCPU IO bus master.
package bf_io_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_APH,
    ST_DPH,
    ST_ACK
  } state_t;

  localparam logic [1:0] IO_ADDR_DATA = 2'b00;
  localparam logic [1:0] IO_ADDR_DIV0 = 2'b10;
  localparam logic [1:0] IO_ADDR_DIV1 = 2'b11;

endpackage

// File: rtl/bf_io_master.sv
// IO bus initiator: programs and verifies the UART baud divisors after reset,
// then turns bfCPU put/get requests into single non-pipelined bus transfers.
module bf_io_master
  import bf_io_pkg::*;
#(
  parameter logic [7:0] DIV0_INIT = 8'd9,
  parameter logic [7:0] DIV1_INIT = 8'd2
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       PUT_REQ,
  input  logic [7:0] PUT_DATA,
  output logic       PUT_ACK,
  input  logic       GET_REQ,
  output logic [7:0] GET_DATA,
  output logic       GET_ACK,
  output logic       INIT_DONE,
  output logic       INIT_ERR,
  output logic       IO_REQ,
  output logic       IO_WRITE,
  output logic [1:0] IO_ADDR,
  output logic [7:0] IO_WDATA,
  input  logic [7:0] IO_RDATA,
  input  logic       IO_RDY
);

  state_t     state;
  logic [1:0] step;

  logic       init_write;
  logic [1:0] init_addr;
  logic [7:0] init_wdata;
  logic [7:0] init_expect;

  // Init step decode: two divisor writes followed by two read-backs.
  always_comb begin
    init_write  = 1'b0;
    init_addr   = IO_ADDR_DIV0;
    init_wdata  = '0;
    init_expect = '0;
    case (step)
      2'd0: begin
        init_write = 1'b1;
        init_addr  = IO_ADDR_DIV0;
        init_wdata = DIV0_INIT;
      end
      2'd1: begin
        init_write = 1'b1;
        init_addr  = IO_ADDR_DIV1;
        init_wdata = DIV1_INIT;
      end
      2'd2: begin
        init_addr   = IO_ADDR_DIV0;
        init_expect = DIV0_INIT;
      end
      default: begin
        init_addr   = IO_ADDR_DIV1;
        init_expect = DIV1_INIT;
      end
    endcase
  end

  // Transfer sequencer; all bus and CPU-side outputs are registered here.
  // INIT_DONE doubles as the "current transfer is a CPU op" marker in DPH.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state     <= ST_INIT;
      step      <= '0;
      IO_REQ    <= 1'b0;
      IO_WRITE  <= 1'b0;
      IO_ADDR   <= '0;
      IO_WDATA  <= '0;
      PUT_ACK   <= 1'b0;
      GET_ACK   <= 1'b0;
      GET_DATA  <= '0;
      INIT_DONE <= 1'b0;
      INIT_ERR  <= 1'b0;
    end else begin
      PUT_ACK <= 1'b0;
      GET_ACK <= 1'b0;
      case (state)
        ST_INIT: begin
          IO_REQ   <= 1'b1;
          IO_WRITE <= init_write;
          IO_ADDR  <= init_addr;
          IO_WDATA <= init_wdata;
          state    <= ST_APH;
        end
        ST_IDLE: begin
          if (PUT_REQ) begin
            IO_REQ   <= 1'b1;
            IO_WRITE <= 1'b1;
            IO_ADDR  <= IO_ADDR_DATA;
            IO_WDATA <= PUT_DATA;
            state    <= ST_APH;
          end else if (GET_REQ) begin
            IO_REQ   <= 1'b1;
            IO_WRITE <= 1'b0;
            IO_ADDR  <= IO_ADDR_DATA;
            IO_WDATA <= '0;
            state    <= ST_APH;
          end
        end
        ST_APH: begin
          if (IO_RDY) begin
            IO_REQ <= 1'b0;
            state  <= ST_DPH;
          end
        end
        ST_DPH: begin
          if (IO_RDY) begin
            if (!INIT_DONE) begin
              if (!IO_WRITE && (IO_RDATA != init_expect)) begin
                INIT_ERR <= 1'b1;
              end
              step <= step + 2'd1;
              if (step == 2'd3) begin
                INIT_DONE <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                state <= ST_INIT;
              end
            end else begin
              if (!IO_WRITE) begin
                GET_DATA <= IO_RDATA;
              end
              PUT_ACK <= IO_WRITE;
              GET_ACK <= !IO_WRITE;
              state   <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
